// File: rtl/sha256_padder.sv
`default_nettype none
// ============================================================================
// Module   : sha256_padder
// Brief    : Byte-stream SHA-256 message padder emitting 512-bit blocks.
// Revision : 1.0 - initial release
// ============================================================================
module sha256_padder #(
  parameter int CNT_W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic [511:0] block_data,
  output logic         block_valid,
  output logic         block_last,
  input  logic         block_ready
);

  typedef enum logic [0:0] {S_FILL, S_EMIT} state_t;
  typedef enum logic [1:0] {P_NONE, P_LENONLY, P_PADLEN} pend_t;

  state_t             r_state, w_state;
  pend_t              r_pend, w_pend;
  logic [5:0]         r_idx, w_idx;
  logic [CNT_W-1:0]   r_count, w_count;
  logic [63:0]        r_len, w_len;
  logic [511:0]       r_data, w_data;
  logic               r_last, w_last;

  logic [CNT_W-1:0]   w_cnt_inc;
  logic [63:0]        w_len_new;
  logic [6:0]         w_n;

  assign in_ready    = (r_state == S_FILL);
  assign block_valid = (r_state == S_EMIT);
  assign block_data  = r_data;
  assign block_last  = r_last;

  assign w_cnt_inc = r_count + 1'b1;
  assign w_len_new = 64'(w_cnt_inc) << 3;
  assign w_n       = {1'b0, r_idx} + 7'd1;

  always_comb begin
    w_state = r_state;
    w_pend  = r_pend;
    w_idx   = r_idx;
    w_count = r_count;
    w_len   = r_len;
    w_data  = r_data;
    w_last  = r_last;
    case (r_state)
      S_FILL: begin
        if (in_valid) begin
          w_count = w_cnt_inc;
          // Byte b of the block sits at [511-8b -: 8]; pad bytes follow the last byte.
          for (int b = 0; b < 64; b++) begin
            if (6'(b) == r_idx)
              w_data[8*(63-b) +: 8] = in_data;
            else if (in_last && (7'(b) == w_n))
              w_data[8*(63-b) +: 8] = 8'h80;
            else if (in_last && (7'(b) > w_n))
              w_data[8*(63-b) +: 8] = 8'h00;
          end
          if (in_last) begin
            w_state = S_EMIT;
            w_idx   = 6'd0;
            w_len   = w_len_new;
            if (w_n <= 7'd55) begin
              w_data[63:0] = w_len_new;
              w_last       = 1'b1;
              w_pend       = P_NONE;
            end else if (w_n <= 7'd63) begin
              w_last = 1'b0;
              w_pend = P_LENONLY;
            end else begin
              w_last = 1'b0;
              w_pend = P_PADLEN;
            end
          end else if (r_idx == 6'd63) begin
            w_state = S_EMIT;
            w_idx   = 6'd0;
            w_last  = 1'b0;
            w_pend  = P_NONE;
          end else begin
            w_idx = r_idx + 6'd1;
          end
        end
      end
      S_EMIT: begin
        if (block_ready) begin
          case (r_pend)
            P_LENONLY: begin
              w_data = {448'b0, r_len};
              w_last = 1'b1;
              w_pend = P_NONE;
            end
            P_PADLEN: begin
              w_data = {8'h80, 440'b0, r_len};
              w_last = 1'b1;
              w_pend = P_NONE;
            end
            default: begin
              w_state = S_FILL;
              if (r_last) w_count = '0;
            end
          endcase
        end
      end
      default: w_state = S_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_FILL;
      r_pend  <= P_NONE;
      r_idx   <= 6'd0;
      r_count <= '0;
      r_len   <= 64'd0;
      r_data  <= 512'd0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_pend  <= w_pend;
      r_idx   <= w_idx;
      r_count <= w_count;
      r_len   <= w_len;
      r_data  <= w_data;
      r_last  <= w_last;
    end
  end

endmodule
`default_nettype wire
